// File: rtl/icache_nway.sv
// Blocking N-way set-associative instruction cache: fetch lookup, line refill and fence.i sweep.
// Hit data returns one cycle after addr_ok; a miss holds rd_req until rd_ready, then takes NBEATS ret_valid beats.
module icache_nway #(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 16,
    parameter int BEAT_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic              fence_i,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              fence_done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic              ret_valid,
    input  logic [BEAT_W-1:0] ret_data
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int NBEATS = LINE_BYTES * 8 / BEAT_W;
    localparam int WPL    = LINE_BYTES / 4;
    localparam int WPB    = BEAT_W / 32;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WRD_W  = (OFF_W > 2) ? OFF_W - 2 : 1;
    localparam int BCNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, INVAL} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] req_addr_q;
    logic [WAY_W-1:0]  victim_q;
    logic [BCNT_W-1:0] beat_cnt;
    logic [IDX_W-1:0]  sweep_cnt;
    logic              fence_done_q;

    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [31:0]       data_mem [WAYS][SETS][WPL];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAY_W-1:0]  rr_q     [SETS];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WRD_W-1:0]  word_idx;
    logic              hit, any_inv, last_beat;
    logic [WAY_W-1:0]  hit_way, inv_way, victim, rr_next;

    assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx   = req_addr_q[OFF_W +: IDX_W];
    assign word_idx  = WRD_W'(req_addr_q[OFF_W-1:0] >> 2);
    assign last_beat = (beat_cnt == BCNT_W'(NBEATS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Scan downwards so the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign rr_next = (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
    assign victim  = any_inv ? inv_way : rr_q[req_idx];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fence_i) state_d = INVAL;
                     else if (valid) state_d = LOOKUP;
            LOOKUP:  state_d = hit ? IDLE : MISS;
            MISS:    if (rd_ready) state_d = REFILL;
            REFILL:  if (ret_valid && last_beat) state_d = LOOKUP;
            INVAL:   if (sweep_cnt == IDX_W'(SETS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign addr_ok    = (state_q == IDLE);
    assign data_ok    = (state_q == LOOKUP) && hit;
    assign rdata      = data_ok ? data_mem[hit_way][req_idx][word_idx] : 32'h0;
    assign rd_req     = (state_q == MISS);
    assign rd_addr    = rd_req ? {req_tag, req_idx, OFF_W'(0)} : '0;
    assign fence_done = fence_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            victim_q     <= '0;
            beat_cnt     <= '0;
            sweep_cnt    <= '0;
            fence_done_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            fence_done_q <= 1'b0;
            case (state_q)
                IDLE: if (!fence_i && valid) req_addr_q <= addr;
                LOOKUP: begin
                    if (!hit) begin
                        victim_q                 <= victim;
                        // Old contents are gone once beats start landing.
                        valid_q[req_idx][victim] <= 1'b0;
                        if (!any_inv) rr_q[req_idx] <= rr_next;
                    end
                end
                REFILL: begin
                    if (ret_valid) begin
                        if (last_beat) begin
                            beat_cnt                   <= '0;
                            valid_q[req_idx][victim_q] <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                INVAL: begin
                    valid_q[sweep_cnt] <= '0;
                    if (sweep_cnt == IDX_W'(SETS - 1)) begin
                        sweep_cnt    <= '0;
                        fence_done_q <= 1'b1;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == REFILL && ret_valid) begin
            for (int k = 0; k < WPB; k++) begin
                data_mem[victim_q][req_idx][WRD_W'(int'(beat_cnt) * WPB + k)] <= ret_data[k*32 +: 32];
            end
            if (last_beat) tag_mem[victim_q][req_idx] <= req_tag;
        end
    end
endmodule

// File: tb/tb_icache_nway.sv
// Scoreboarded bench for icache_nway with a behavioural refill memory.
module tb_icache_nway;
    localparam int NBEATS = 2;
    localparam int SETS   = 64;

    logic        clk, rst, valid, fence_i;
    logic [31:0] addr;
    logic        addr_ok, data_ok, fence_done, rd_req, rd_ready, ret_valid;
    logic [31:0] rdata, rd_addr;
    logic [63:0] ret_data;

    int n_checks = 0;
    int n_fail   = 0;
    int refill_cnt = 0;
    int rdreq_cycles = 0;
    int stall_left = 0;
    int mem_phase, mem_beat;
    logic [31:0] mem_line;
    logic [31:0] exp_line = 32'h0;
    logic [31:0] sb_q[$];

    icache_nway dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .fence_i(fence_i),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .fence_done(fence_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .ret_valid(ret_valid), .ret_data(ret_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic timed_out(input string tag);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", tag);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a[31:4] == 28'h8000000) w = 32'h1111_1111 * (32'(a[3:2]) + 32'd1);
        else                        w = a ^ 32'h5EED_C0DE;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!addr_ok && n < 200) begin
            tick();
            n++;
        end
        if (!addr_ok) timed_out("idle_wait");
    endtask

    // Refill memory: drives at posedge+1, the main thread at posedge+2.
    initial begin
        rd_ready  = 1'b0;
        ret_valid = 1'b0;
        ret_data  = 64'h0;
        mem_phase = 0;
        mem_beat  = 0;
        mem_line  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mem_phase = 0;
                rd_ready  = 1'b0;
                ret_valid = 1'b0;
            end else if (mem_phase == 0) begin
                ret_valid = 1'b0;
                rd_ready  = 1'b0;
                if (rd_req) begin
                    rdreq_cycles++;
                    check("rd_addr", rd_addr, exp_line);
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        rd_ready  = 1'b1;
                        mem_line  = rd_addr;
                        mem_phase = 1;
                        mem_beat  = 0;
                        refill_cnt++;
                    end
                end
            end else begin
                rd_ready  = 1'b0;
                ret_valid = 1'b1;
                ret_data  = {mem_word(mem_line + 32'(8 * mem_beat + 4)),
                             mem_word(mem_line + 32'(8 * mem_beat))};
                mem_beat++;
                if (mem_beat == NBEATS) mem_phase = 0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input bit exp_miss);
        int lat;
        int rc0;
        logic [31:0] exp;
        wait_idle();
        check("rdata_idle", rdata, 32'h0);
        valid    = 1'b1;
        addr     = a;
        exp_line = a & ~32'hF;
        rc0      = refill_cnt;
        sb_q.push_back(mem_word(a & ~32'h3));
        tick();
        valid = 1'b0;
        lat   = 1;
        while (!data_ok && lat < 200) begin
            tick();
            lat++;
        end
        if (!data_ok) begin
            timed_out("data_ok_wait");
            void'(sb_q.pop_front());
        end else begin
            exp = sb_q.pop_front();
            check("rdata", rdata, exp);
            check("miss", refill_cnt != rc0, exp_miss);
            if (!exp_miss) check("hit_latency", lat, 1);
        end
        tick();
    endtask

    task automatic fence(input bit with_valid, input logic [31:0] a);
        int n = 0;
        int dok = 0;
        int rc0;
        wait_idle();
        fence_i = 1'b1;
        valid   = with_valid;
        addr    = a;
        rc0     = refill_cnt;
        tick();
        fence_i = 1'b0;
        valid   = 1'b0;
        while (!addr_ok && n < 500) begin
            if (data_ok) dok++;
            tick();
            n++;
        end
        check("fence_busy_cycles", n, SETS);
        check("fence_done", fence_done, 1);
        check("fence_no_refill", refill_cnt - rc0, 0);
        check("fence_no_data", dok, 0);
        tick();
        check("fence_done_pulse", fence_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rq0, n;
        logic [31:0] a;
        rst = 1'b1; valid = 1'b0; fence_i = 1'b0; addr = 32'h0;
        repeat (3) tick();
        check("rst_data_ok", data_ok, 0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_addr", rd_addr, 32'h0);
        check("rst_fence_done", fence_done, 0);
        rst = 1'b0;
        tick();
        check("addr_ok_after_rst", addr_ok, 1);

        // Cold miss then hit on the same line.
        fetch(32'h8000_0004, 1);
        fetch(32'h8000_000C, 0);

        // Set-0 conflicts: third fill evicts way 0 via round-robin.
        fetch(32'h8000_0400, 1);
        fetch(32'h8000_0800, 1);
        fetch(32'h8000_0404, 0);
        fetch(32'h8000_0000, 1);
        fetch(32'h8000_0808, 0);

        // Fence with a simultaneous fetch request; the fetch is dropped.
        fence(1'b1, 32'h8000_0040);
        fetch(32'h8000_0400, 1);

        // Refill backpressure.
        stall_left = 5;
        rq0 = rdreq_cycles;
        fetch(32'h8000_0100, 1);
        check("bp_rd_req_cycles", rdreq_cycles - rq0, 6);

        // Misses then hits across several sets.
        for (int i = 0; i < 4; i++) begin
            a = 32'h9000_0000 + 32'(i * 32'h30) + 32'(i * 4);
            fetch(a, 1);
            fetch(a ^ 32'h8, 0);
        end

        // Reset after the first refill beat.
        wait_idle();
        valid    = 1'b1;
        addr     = 32'h8000_2010;
        exp_line = 32'h8000_2010;
        sb_q.push_back(mem_word(32'h8000_2010));
        tick();
        valid = 1'b0;
        n = 0;
        while (!ret_valid && n < 100) begin
            tick();
            n++;
        end
        if (!ret_valid) timed_out("beat0_wait");
        tick();
        rst = 1'b1;
        #1;
        check("midrst_data_ok", data_ok, 0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_rd_req", rd_req, 0);
        check("midrst_rd_addr", rd_addr, 32'h0);
        check("midrst_fence_done", fence_done, 0);
        repeat (2) tick();
        rst = 1'b0;
        sb_q.delete();
        check("addr_ok_after_midrst", addr_ok, 1);
        tick();
        fetch(32'h8000_2010, 1);
        fetch(32'h8000_0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch/memory address width.
REQ-002 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2 or 4.
REQ-003 SHALL have parameter SETS, default 64, sets per way; power of two, at least 2.
REQ-004 SHALL have parameter LINE_BYTES, default 16, line size; power of two, at least BEAT_W/8.
REQ-005 SHALL have parameter BEAT_W, default 64, refill beat width; 32 or 64.
REQ-006 SHALL derive OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W and NBEATS=LINE_BYTES*8/BEAT_W.
REQ-007 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port valid  input  1  fetch request.
REQ-010 SHALL have port addr  input  ADDR_W  fetch byte address; addr[1:0] ignored.
REQ-011 SHALL have port fence_i  input  1  invalidate-all request.
REQ-012 SHALL have port addr_ok  output  1  request or fence accepted this cycle.
REQ-013 SHALL have port data_ok  output  1  one-cycle pulse, rdata valid.
REQ-014 SHALL have port rdata  output  32  fetched word.
REQ-015 SHALL have port fence_done  output  1  one-cycle pulse, invalidation complete.
REQ-016 SHALL have port rd_req  output  1  line refill request.
REQ-017 SHALL have port rd_addr  output  ADDR_W  line-aligned refill address.
REQ-018 SHALL have port rd_ready  input  1  memory accepts rd_req.
REQ-019 SHALL have port ret_valid  input  1  refill beat valid.
REQ-020 SHALL have port ret_data  input  BEAT_W  refill beat; beat 0 is the lowest line address.

Function
REQ-021 SHALL implement states IDLE, LOOKUP, MISS, REFILL and INVAL.
REQ-022 SHALL drive addr_ok=1 only in IDLE.
REQ-023 SHALL, in IDLE with fence_i=1, accept the fence and go to INVAL; fence_i has priority over valid, and the request is not accepted.
REQ-024 SHALL, in IDLE with valid=1 and fence_i=0, register addr and go to LOOKUP.
REQ-025 SHALL ignore valid and fence_i outside IDLE.
REQ-026 SHALL, in LOOKUP on a hit (valid bit set and tag equal in any way), pulse data_ok with rdata equal to word addr[OFF_W-1:2] of the hit line, then return to IDLE; hit latency is 1 cycle after acceptance.
REQ-027 SHALL drive rdata=0 whenever data_ok=0.
REQ-028 SHALL, in LOOKUP on a miss, select a victim and go to MISS.
REQ-029 SHALL choose as victim the lowest-numbered invalid way; if all ways are valid, the way indicated by the per-set round-robin pointer, which then increments modulo WAYS.
REQ-030 SHALL not update replacement state on hits.
REQ-031 SHALL, in MISS, hold rd_req=1 and rd_addr={tag,index,OFF_W'b0} stable until rd_ready=1, then go to REFILL.
REQ-032 SHALL, in REFILL, write each ret_valid beat into the victim line at the beat counter position, starting from 0.
REQ-033 SHALL ignore ret_valid outside REFILL.
REQ-034 SHALL, on beat NBEATS-1, set the victim's valid bit and tag and go to LOOKUP, which then hits.
REQ-035 SHALL, in INVAL, clear one set's valid bits (all ways) per cycle, sweeping index 0..SETS-1, then pulse fence_done and go to IDLE; the sweep takes SETS cycles.
REQ-036 SHALL hold tag and data arrays in flops without reset; only valid bits, replacement pointers, FSM, counters and registered outputs are reset.

Reset
REQ-037 SHALL, while rst=1 regardless of clk, force IDLE, clear all valid bits and replacement pointers, zero the beat and sweep counters, and drive data_ok=0, rdata=0, rd_req=0, rd_addr=0 and fence_done=0.
REQ-038 SHALL drive addr_ok=1 in the first cycle after rst deasserts.
REQ-039 SHALL discard a partially refilled line when reset arrives mid-REFILL; the line remains invalid.

Verification (defaults: TAG_W=22, IDX_W=6, OFF_W=4, NBEATS=2)
REQ-040 SHALL cover a cold miss at 0x8000_0004: rd_req=1 with rd_addr=0x8000_0000; beats 0x2222_2222_1111_1111 then 0x4444_4444_3333_3333 -> data_ok with rdata 0x2222_2222; then 0x8000_000C -> data_ok 1 cycle after addr_ok, rdata 0x4444_4444, no rd_req.
REQ-041 SHALL cover set conflict: fill 0x8000_0000, 0x8000_0400 and 0x8000_0800 (all set 0); the third fill evicts way 0 -> 0x8000_0000 misses, 0x8000_0400 hits.
REQ-042 SHALL cover fence: after the fills, fence_i=1 for 1 cycle -> addr_ok=0 for 64 cycles, then fence_done pulses; next fetch of 0x8000_0400 misses.
REQ-043 SHALL cover backpressure: rd_ready=0 for 5 cycles during MISS -> rd_req=1 and rd_addr constant throughout; refill completes normally.
REQ-044 SHALL cover reset after refill beat 0: outputs immediately take reset values; a later fetch of the same address misses and refetches.
REQ-045 SHALL cover valid=1 with fence_i=1 in IDLE: fence executes; no LOOKUP or rd_req for that addr.
